// File: rtl/divide_32bit_seq_pkg.sv
// Shared constants and state encoding for the sequential 32/32 unsigned divider.
package divide_32bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam logic [4:0]  ITER_LAST     = 5'd31;
  localparam logic [31:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/subtract_32bit.sv
// 32-bit subtractor Z = X - Y - C_IN; C_OUT is the borrow out (set when X < Y + C_IN).
module subtract_32bit (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        C_IN,
  output logic [31:0] Z,
  output logic        C_OUT
);

  logic [32:0] diff;

  always_comb begin
    diff  = {1'b0, X} - {1'b0, Y} - {32'd0, C_IN};
    Z     = diff[31:0];
    C_OUT = diff[32];
  end

endmodule

// File: rtl/divide_32bit_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a shared subtractor.
module divide_32bit_seq
  import divide_32bit_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] QUOTIENT,
  output logic [31:0] REMAINDER,
  output logic        DIV_ZERO
);

  div_state_t  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] d_q, d_d;
  logic [31:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        divz_q, divz_d;

  logic [31:0] shifted;
  logic [31:0] sub_z;
  logic        sub_borrow;
  logic        qbit;

  assign shifted = {p_q[30:0], a_q[31]};

  subtract_32bit u_sub (
    .X     (shifted),
    .Y     (d_q),
    .C_IN  (1'b0),
    .Z     (sub_z),
    .C_OUT (sub_borrow)
  );

  // A set P[31] means the true partial remainder is >= 2^32 > D, so the subtract must succeed.
  assign qbit = p_q[31] | ~sub_borrow;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    divz_d  = divz_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          a_d   = DIVIDEND;
          d_d   = DIVISOR;
          p_d   = 32'd0;
          cnt_d = 5'd0;
          if (DIVISOR == 32'd0) begin
            state_d = FIN;
            quot_d  = DIVZ_QUOTIENT;
            rem_d   = DIVIDEND;
            divz_d  = 1'b1;
          end else begin
            state_d = RUN;
            divz_d  = 1'b0;
          end
        end
      end
      RUN: begin
        p_d   = qbit ? sub_z : shifted;
        a_d   = {a_q[30:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = FIN;
          quot_d  = a_d;
          rem_d   = p_d;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      d_q     <= 32'd0;
      p_q     <= 32'd0;
      cnt_q   <= 5'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = quot_q;
  assign REMAINDER = rem_q;
  assign DIV_ZERO  = divz_q;

endmodule

// File: tb/tb_divide_32bit_seq.sv
// Randomized and directed bench for divide_32bit_seq against a plain-arithmetic reference.
module tb_divide_32bit_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] QUOTIENT;
  logic [31:0] REMAINDER;
  logic        DIV_ZERO;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  divide_32bit_seq dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .DIV_ZERO  (DIV_ZERO)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents operands with START for exactly one rising edge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    DIVIDEND = $urandom;
    DIVISOR  = $urandom;
  endtask

  // Full transaction: latency, busy span, result hold during the run, results, and single-cycle DONE.
  task automatic runCheck(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_q, exp_r, prev_q, prev_r;
    logic        exp_z;
    int          cyc, busy_cnt, exp_lat;
    logic        hold_ok;
    exp_z   = (b == 32'd0);
    exp_q   = exp_z ? 32'hFFFF_FFFF : a / b;
    exp_r   = exp_z ? a : a % b;
    exp_lat = exp_z ? 0 : 32;
    prev_q  = QUOTIENT;
    prev_r  = REMAINDER;
    hold_ok = 1'b1;
    applyStimulus(a, b);
    cyc      = 0;
    busy_cnt = BUSY ? 1 : 0;
    while (!DONE && cyc < 100) begin
      if (QUOTIENT !== prev_q || REMAINDER !== prev_r) hold_ok = 1'b0;
      @(negedge CLK);
      cyc++;
      if (BUSY) busy_cnt++;
    end
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_quot"}, QUOTIENT, exp_q);
    checkOutput({tag, "_rem"}, REMAINDER, exp_r);
    checkOutput({tag, "_divz"}, {31'd0, DIV_ZERO}, {31'd0, exp_z});
    if (!exp_z) checkOutput({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    @(negedge CLK);
    if (BUSY) busy_cnt++;
    checkOutput({tag, "_busycnt"}, busy_cnt, exp_lat + 1);
    checkOutput({tag, "_donepulse"}, {31'd0, DONE}, 32'd0);
    checkOutput({tag, "_quot_held"}, QUOTIENT, exp_q);
  endtask

  initial begin
    int          done_cnt, cyc, stray_done;
    logic [31:0] ra, rb;

    RST_N    = 1'b0;
    START    = 1'b0;
    DIVIDEND = 32'd0;
    DIVISOR  = 32'd0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_done", {31'd0, DONE}, 32'd0);
    checkOutput("rst_quot", QUOTIENT, 32'd0);
    checkOutput("rst_rem", REMAINDER, 32'd0);
    checkOutput("rst_divz", {31'd0, DIV_ZERO}, 32'd0);
    RST_N = 1'b1;

    runCheck("d100_7", 32'd100, 32'd7);
    runCheck("msb_path", 32'hFFFF_FFFF, 32'h8000_0001);
    runCheck("d7_9", 32'd7, 32'd9);
    runCheck("max_by1", 32'hFFFF_FFFF, 32'd1);
    runCheck("d5_0", 32'd5, 32'd0);
    runCheck("d9_3", 32'd9, 32'd3);

    // START pulses while busy (mid-run and on the DONE cycle) must be ignored.
    applyStimulus(32'd100, 32'd7);
    done_cnt = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
      if (n == 32) begin
        checkOutput("busyign_quot", QUOTIENT, 32'd14);
        checkOutput("busyign_rem", REMAINDER, 32'd2);
      end
      DIVIDEND = 32'd50;
      DIVISOR  = 32'd5;
      START    = (n == 10 || n == 32 || n == 33);
    end
    checkOutput("busyign_donecnt", done_cnt, 32'd1);
    checkOutput("busyign_quot_idle", QUOTIENT, 32'd14);
    @(negedge CLK);
    START = 1'b0;
    cyc = 0;
    while (!DONE && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("firstidle_latency", cyc, 32'd32);
    checkOutput("firstidle_quot", QUOTIENT, 32'd10);
    checkOutput("firstidle_rem", REMAINDER, 32'd0);
    @(negedge CLK);

    // Reset in the middle of a run aborts it without a DONE pulse.
    applyStimulus(32'd100, 32'd7);
    repeat (15) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("midrst_done", {31'd0, DONE}, 32'd0);
    checkOutput("midrst_quot", QUOTIENT, 32'd0);
    checkOutput("midrst_rem", REMAINDER, 32'd0);
    checkOutput("midrst_divz", {31'd0, DIV_ZERO}, 32'd0);
    stray_done = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) stray_done++;
    end
    checkOutput("midrst_nodone", stray_done, 32'd0);
    runCheck("after_rst", 32'd100, 32'd7);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 255);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      runCheck($sformatf("rand%0d", i), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
